add38_share_arb: RTL
====================

// Module: add38_share_arb
// PURPOSE
//   Shares one add_38bits adder between N_REQ requesters (mantissa/exponent/rounding paths of the FP multiplier).
//   Per-requester valid/ready request channel in, per-requester valid/ready response channel out.
//   Single registered result stage: 1-cycle latency, 1 op/cycle throughput under no backpressure.
//   Arbitration is round-robin (or fixed priority) over pending requests.
// PARAMETERS
//   DATA_W  38  operand/result width; only 38 is supported (matches add_38bits)
//   N_REQ   2   number of requesters; supported 2..4
//   RR_EN   1   1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//   i_clk            in   1             clock, rising edge
//   i_rst            in   1             reset, asynchronous, active-high
//   i_req_valid      in   N_REQ         request valid per requester
//   o_req_ready      out  N_REQ         request accepted (one-hot or zero)
//   i_req_data_one   in   N_REQ*DATA_W  operand A, requester k at [k*DATA_W +: DATA_W]
//   i_req_data_two   in   N_REQ*DATA_W  operand B, same packing
//   i_req_carry      in   N_REQ         carry-in per requester
//   o_rsp_valid      out  N_REQ         response valid, one-hot to owner of held result
//   i_rsp_ready      in   N_REQ         response consumed per requester
//   o_rsp_data       out  DATA_W        held sum, shared by all response channels
//   o_rsp_carry      out  1             held carry-out
//   o_busy           out  1             result register occupied
// BEHAVIOUR
//   - Reset (async, i_rst=1): state S_IDLE, o_rsp_valid=0, o_rsp_data=0, o_rsp_carry=0, o_busy=0, rr pointer=0.
//   - FSM: S_IDLE (result empty), S_HOLD (result held for owner g).
//   - can_accept = (state==S_IDLE) | (state==S_HOLD & i_rsp_ready[g]).
//   - grant: if can_accept & |i_req_valid -> pick requester; o_req_ready[pick]=1, all others 0. Else o_req_ready=0.
//   - Pick (RR_EN=1): first valid index searching from rr pointer upward, wrapping N_REQ-1 -> 0.
//     Pick (RR_EN=0): lowest valid index. rr pointer ignored.
//   - On accept: adder fed combinationally from picked operands; {carry,sum} registered at next edge;
//     g <= pick; state -> S_HOLD; rr pointer <= (pick+1) mod N_REQ.
//   - S_HOLD, i_rsp_ready[g]=1, no new accept -> S_IDLE, o_rsp_valid cleared. i_rsp_ready[g]=0 -> hold all outputs stable.
//   - i_rsp_ready of non-owners ignored. o_rsp_data/o_rsp_carry hold last value in S_IDLE.
//   - Latency: request accepted cycle T -> o_rsp_valid[pick]=1 at T+1. Back-to-back accept allowed same cycle as response consume.
//   - Arithmetic: 38-bit unsigned add plus carry-in; overflow reported only on o_rsp_carry, sum wraps mod 2^38.
//   - o_req_ready depends combinationally on i_req_valid and i_rsp_ready (documented path; no loop to i_req_valid allowed upstream).
//   - Requester must hold valid and operands stable until ready; a dropped valid is not an error and is not arbitrated.
//   - Reset asserted mid-operation: held result discarded, no response issued, pointer returns to 0.
//   - o_busy = (state==S_HOLD).
// STRUCTURE
//   - Package add38_share_pkg: localparam ADD_W=38; typedef enum logic {S_IDLE,S_HOLD} arb_state_e; typedef logic [ADD_W-1:0] add_word_t.
//   - Sub-module add38_rr_pick: combinational pick (valid vector, pointer, RR_EN) -> one-hot grant + index.
//   - Instantiates existing add_38bits once; operand mux and result register in this module.
// TESTING
//   - Reset: i_rst pulse mid-run -> all outputs 0 asynchronously, no o_rsp_valid after release until new request.
//   - Single op: req0 A=38'h00_0000_0001, B=38'h00_0000_0002, cin=1 accepted T -> T+1 o_rsp_valid=2'b01, data=4, carry=0.
//   - Wrap: req1 A=38'h3F_FFFF_FFFF, B=1, cin=0 -> data=0, carry=1, o_rsp_valid=2'b10.
//   - Contention RR_EN=1: both valid continuously, rsp_ready=1 -> grants 0,1,0,1 each cycle, responses every cycle.
//   - Backpressure: owner i_rsp_ready=0 for 3 cycles -> o_req_ready=0, outputs stable; ready=1 -> new accept same cycle.
//   - Fixed priority RR_EN=0: both valid -> req0 granted every accept, req1 starved until req0 valid drops.

Source files
------------

// File: rtl/add38_share_arb_pkg.sv
// Shared types for the add_38bits sharing arbiter: adder width, FSM states and
// the index-width helper used by the arbiter and its pick logic.
package add38_share_pkg;
  localparam int ADD_W = 38;

  typedef enum logic {S_IDLE, S_HOLD} arb_state_e;

  typedef logic [ADD_W-1:0] add_word_t;

  function automatic int idx_w(input int n_req);
    return (n_req > 2) ? 2 : 1;
  endfunction
endpackage

// File: rtl/add38_share_arb_if.sv
// Request/response bundle between N_REQ requesters and the shared adder arbiter.
interface add38_share_arb_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 38
);
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_REQ*DATA_W-1:0] i_req_data_one;
  logic [N_REQ*DATA_W-1:0] i_req_data_two;
  logic [N_REQ-1:0]        i_req_carry;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [N_REQ-1:0]        i_rsp_ready;
  logic [DATA_W-1:0]       o_rsp_data;
  logic                    o_rsp_carry;
  logic                    o_busy;

  modport master (
    output i_req_valid, i_req_data_one, i_req_data_two, i_req_carry, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_carry, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data_one, i_req_data_two, i_req_carry, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_carry, o_busy
  );
endinterface

// File: rtl/add38_share_arb_rr_pick.sv
// Combinational requester pick: round-robin from a pointer, or lowest index
// when RR_EN=0. Produces a one-hot grant, its index and an any-valid flag.
module add38_rr_pick
  import add38_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int RR_EN = 1
) (
  input  logic [N_REQ-1:0]        i_valid,
  input  logic [idx_w(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]        o_grant,
  output logic [idx_w(N_REQ)-1:0] o_idx,
  output logic                    o_any
);
  localparam int IDX_W = idx_w(N_REQ);

  int unsigned cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // Candidate order starts at the pointer and wraps; fixed priority ignores it.
      cand = (RR_EN != 0) ? (32'(i_ptr) + k) % 32'(N_REQ) : k;
      if (!o_any && i_valid[cand]) begin
        o_any         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/add_38bits.sv
// 38-bit unsigned adder with carry-in and carry-out.
module add_38bits (
  input  logic [37:0] i_a,
  input  logic [37:0] i_b,
  input  logic        i_carry,
  output logic [37:0] o_sum,
  output logic        o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {38'b0, i_carry};
endmodule

// File: rtl/add38_share_arb.sv
// Shares one add_38bits between N_REQ requesters with a single registered
// result stage; a held result blocks new accepts until its owner consumes it.
module add38_share_arb
  import add38_share_pkg::*;
#(
  parameter int DATA_W = 38,
  parameter int N_REQ  = 2,
  parameter int RR_EN  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  add38_share_arb_if.slave  bus
);
  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  add_word_t         sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              can_accept;
  logic              accept;

  add_word_t         op_a, op_b, add_sum;
  logic              op_c, add_cout;

  add38_rr_pick #(
    .N_REQ (N_REQ),
    .RR_EN (RR_EN)
  ) u_pick (
    .i_valid (bus.i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  // Consuming the held result frees the register for a same-cycle accept.
  assign can_accept = (state_q == S_IDLE) ||
                      ((state_q == S_HOLD) && bus.i_rsp_ready[owner_q]);
  assign accept     = can_accept && pick_any;

  always_comb begin
    op_a = '0;
    op_b = '0;
    op_c = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_grant[k]) begin
        op_a = bus.i_req_data_one[k*DATA_W +: DATA_W];
        op_b = bus.i_req_data_two[k*DATA_W +: DATA_W];
        op_c = bus.i_req_carry[k];
      end
    end
  end

  add_38bits u_add (
    .i_a     (op_a),
    .i_b     (op_b),
    .i_carry (op_c),
    .o_sum   (add_sum),
    .o_carry (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    rsp_valid_d = '0;
    if (accept) begin
      state_d  = S_HOLD;
      owner_d  = pick_idx;
      rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      sum_d    = add_sum;
      carry_d  = add_cout;
    end else if ((state_q == S_HOLD) && bus.i_rsp_ready[owner_q]) begin
      state_d = S_IDLE;
    end
    if (state_d == S_HOLD) begin
      rsp_valid_d[owner_d] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.o_req_ready = accept ? pick_grant : '0;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = sum_q;
  assign bus.o_rsp_carry = carry_q;
  assign bus.o_busy      = (state_q == S_HOLD);
endmodule
